// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit: data width, ALU control
// encoding, FSM state type and the shift-step mode.
package alu_exec_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LEFT        = 2'd0,
        SH_RIGHT_LOG   = 2'd1,
        SH_RIGHT_ARITH = 2'd2
    } shift_mode_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // Codes above SRA are undefined.
    function automatic logic is_legal(input logic [3:0] op);
        return op <= ALU_SRA;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle for the ALU execution unit.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = alu_exec_unit_pkg::XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_control, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_control, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_shift_step.sv
// Combinational single-position shifter: left, logical right or arithmetic right.
module alu_shift_step
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned XLEN = alu_exec_unit_pkg::XLEN
) (
    input  logic [XLEN-1:0] din,
    input  shift_mode_t     mode,
    output logic [XLEN-1:0] dout_c
);

    always_comb begin
        dout_c = din;
        case (mode)
            SH_LEFT:        dout_c = {din[XLEN-2:0], 1'b0};
            SH_RIGHT_LOG:   dout_c = {1'b0, din[XLEN-1:1]};
            SH_RIGHT_ARITH: dout_c = {din[XLEN-1], din[XLEN-1:1]};
            default:        dout_c = din;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle logic/arithmetic ops, shifts iterated one
// bit per cycle, result held until the consumer takes it.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned XLEN = alu_exec_unit_pkg::XLEN
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_unit_if.slave bus
);

    state_t              state_q, state_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [XLEN-1:0]     alu_res;
    logic [XLEN-1:0]     step_out;
    shift_mode_t         step_mode;

    // Single-cycle result straight from the request; shifts by 0 return a.
    always_comb begin
        alu_res = '0;
        case (bus.alu_control)
            ALU_ADD:  alu_res = bus.a + bus.b;
            ALU_SUB:  alu_res = bus.a - bus.b;
            ALU_AND:  alu_res = bus.a & bus.b;
            ALU_OR:   alu_res = bus.a | bus.b;
            ALU_XOR:  alu_res = bus.a ^ bus.b;
            ALU_SLT:  alu_res = XLEN'($signed(bus.a) < $signed(bus.b));
            ALU_SLTU: alu_res = XLEN'(bus.a < bus.b);
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res = bus.a;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        step_mode = SH_RIGHT_LOG;
        case (op_q)
            ALU_SLL: step_mode = SH_LEFT;
            ALU_SRA: step_mode = SH_RIGHT_ARITH;
            default: step_mode = SH_RIGHT_LOG;
        endcase
    end

    alu_shift_step #(.XLEN(XLEN)) u_shift_step (
        .din    (result_q),
        .mode   (step_mode),
        .dout_c (step_out)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        op_d        = op_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    op_d      = bus.alu_control;
                    cnt_d     = bus.b[SHAMT_W-1:0];
                    illegal_d = 1'b0;
                    if (is_shift(bus.alu_control) && (bus.b[SHAMT_W-1:0] != '0)) begin
                        result_d = bus.a;
                        zero_d   = 1'b0;
                        state_d  = ST_SHIFT;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        illegal_d   = !is_legal(bus.alu_control);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = step_out;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    zero_d      = (step_out == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
            op_q        <= ALU_ADD;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 alu_control  input  4  operation code, using the core's ALU control encoding.
REQ-007 a  input  XLEN  first operand.
REQ-008 b  input  XLEN  second operand; b[4:0] is the shift amount.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  XLEN  operation result.
REQ-012 zero  output  1  result equals 0.
REQ-013 illegal  output  1  accepted alu_control was not a defined code.

Function
REQ-014 Encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SLT, 0110 SLTU, 0111 XOR, 1000 SRL, 1001 SRA; 1010-1111 illegal.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-017 On accept, a, b[4:0] and alu_control SHALL be captured; later input changes SHALL NOT affect the operation.
REQ-018 Non-shift and illegal codes: IDLE -> DONE; out_valid rises on the cycle after accept (latency 1).
REQ-019 ADD/SUB SHALL wrap modulo 2^XLEN; SLT is signed and SLTU unsigned; each yields 1 or 0 zero-extended.
REQ-020 Shift with amount 0: IDLE -> DONE, result = a, latency 1.
REQ-021 Shift with amount n > 0: IDLE -> SHIFT; exactly one bit position per cycle for n cycles, then DONE; out_valid rises n+1 cycles after accept.
REQ-022 SRL SHALL fill with 0; SRA SHALL fill with the captured a[XLEN-1]; SLL SHALL fill with 0.
REQ-023 Illegal codes: result = 0, illegal = 1, zero = 1.
REQ-024 In DONE, result, zero and illegal SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 DONE with out_ready=1: out_valid drops next cycle, state -> IDLE; no new request is accepted in that same cycle.
REQ-026 in_valid while not in IDLE SHALL be ignored, with no state change.
REQ-027 zero SHALL equal (result == 0) whenever out_valid=1.

Reset
REQ-028 Reset SHALL force state IDLE, in_ready=1 on the next cycle, out_valid=0, result=0, zero=0, illegal=0, and the shift counter to 0.
REQ-029 Reset during SHIFT or DONE SHALL abort the operation; no out_valid for it ever appears.
REQ-030 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-031 A shared package SHALL hold XLEN, the ten alu_control code constants and the FSM state type; the control decoder SHALL use the same package.
REQ-032 One sub-module, alu_shift_step, is natural: a combinational one-position shift step (left, logical right, arithmetic right) instantiated once.
REQ-033 The rest SHALL be one FSM plus a datapath register, with no other sub-modules.

Verification
REQ-034 ADD: a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after accept, result=0, zero=1, illegal=0.
REQ-035 SRA: a=0x80000000, b=4 -> out_valid 5 cycles after accept, result=0xF8000000; in_ready=0 throughout.
REQ-036 SLT vs SLTU: a=0xFFFFFFFF, b=1 -> SLT result=1, SLTU result=0.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles after XOR a=0xF0F0F0F0, b=0xFFFF0000 -> result=0x0F0FF0F0 stable; in_valid pulses ignored.
REQ-038 Reset asserted on 2nd SHIFT cycle of SLL b=10 -> IDLE next cycle, out_valid stays 0, next ADD 2+3 returns 5.
REQ-039 alu_control=1111 -> result=0, illegal=1, zero=1, latency 1.
